bp_train_scheduler: RTL and testbench
=====================================

BP_TRAIN_SCHEDULER -- requirements
Module: bp_train_scheduler

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: width of all PC ports.
REQ-002 Parameter IDX_BITS, default 4: predictor table index width.
REQ-003 Parameter DEPTH, default 4 (power of 2, >=2): feedback FIFO entries.
REQ-004 Parameter STARVE_LIMIT, default 3: consecutive deferred training cycles before training is forced.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 i_req_valid  in  1  decode-stage prediction lookup request.
REQ-008 i_req_pc  in  ADDR_WIDTH  PC of the branch being looked up.
REQ-009 i_fb_valid  in  1  EX-stage branch resolution, one-cycle pulse.
REQ-010 i_fb_pc  in  ADDR_WIDTH  resolved branch PC.
REQ-011 i_fb_prediction  in  1  prediction made (1 = TAKEN).
REQ-012 i_fb_outcome  in  1  actual outcome (1 = TAKEN).
REQ-013 o_tbl_en  out  1  table port access this cycle.
REQ-014 o_tbl_we  out  1  1 = training write, 0 = read.
REQ-015 o_tbl_idx  out  IDX_BITS  table index.
REQ-016 o_tbl_outcome  out  1  outcome for training write.
REQ-017 o_tbl_mispred  out  1  prediction != outcome, for training write.
REQ-018 o_req_stall  out  1  lookup denied this cycle; decode holds.
REQ-019 o_fb_drop  out  1  one-cycle pulse: feedback discarded, FIFO full.
REQ-020 o_fifo_count  out  log2(DEPTH)+1  FIFO occupancy.

Function
REQ-021 Index hash SHALL be pc[IDX_BITS+1:2] for both lookup and training.
REQ-022 Feedback SHALL be pushed into FIFO (pc index, prediction, outcome) in the i_fb_valid cycle, visible to the FSM the next cycle.
REQ-023 Push when full SHALL drop the new entry and pulse o_fb_drop, except when a pop occurs the same cycle, in which case the push SHALL be accepted.
REQ-024 FSM states: IDLE, TRAIN_RD, TRAIN_WR; IDLE->TRAIN_RD when FIFO non-empty.
REQ-025 TRAIN_RD: if granted, drive en=1, we=0, idx=head index, go to TRAIN_WR; else remain.
REQ-026 TRAIN_WR: if granted, drive en=1, we=1, idx/outcome/mispred from head, pop head; next state TRAIN_RD if FIFO still non-empty after pop, else IDLE.
REQ-027 Port grant: i_req_valid SHALL win (en=1, we=0, idx=hash(i_req_pc), o_req_stall=0) unless the starvation counter equals STARVE_LIMIT.
REQ-028 Starvation counter SHALL increment each cycle the FSM is in TRAIN_RD/TRAIN_WR and loses the port, clear on any training grant or in IDLE, saturate at STARVE_LIMIT.
REQ-029 When counter == STARVE_LIMIT, training SHALL win and, if i_req_valid, o_req_stall=1 that cycle.
REQ-030 With no request and no training grant, o_tbl_en=0 and o_tbl_idx/outcome/mispred=0.
REQ-031 Table port outputs and o_req_stall SHALL be combinational from state and inputs (zero-latency grant); table read data returns outside this block.

Reset
REQ-032 rst SHALL asynchronously force IDLE, empty FIFO (count 0), starvation counter 0, statistics counters 0.
REQ-033 During reset all outputs SHALL be 0; feedback arriving in reset is discarded without o_fb_drop.
REQ-034 Reset mid TRAIN_RD/TRAIN_WR SHALL abandon the entry; no write issued after release.

Configuration
REQ-035 Macro BP_SCHED_STATS_EN: when defined, outputs o_pred_count[31:0] (accepted lookups) and o_miss_count[31:0] (pushed entries with prediction != outcome), wrapping at 2^32; under SIMULATION, stats_event("branch_pred") / stats_event("branch_miss") per increment.
REQ-036 Without BP_SCHED_STATS_EN the two ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-037 Single fb (pc=0x40, pred=0, out=1), no requests -> cycle+1 read idx 0x0, cycle+2 write idx 0x0 outcome=1 mispred=1, then IDLE, count 0.
REQ-038 fb pc=0x44 with i_req_valid held high -> 3 deferred cycles, 4th cycle training read with o_req_stall=1, next request win, then after 3 more deferrals forced write.
REQ-039 5 fb pulses back-to-back with continuous requests, DEPTH=4 -> 5th pulse o_fb_drop=1, count stays 4.
REQ-040 Full FIFO, fb pulse in same cycle as TRAIN_WR pop -> no drop, count stays 4.
REQ-041 Assert rst during TRAIN_WR -> outputs 0 immediately, count 0, no write after release.
REQ-042 BP_SCHED_STATS_EN defined, 10 lookups and 3 mispredicted fb -> o_pred_count=10, o_miss_count=3.

Source files
------------

// File: rtl/bp_train_scheduler_if.sv
// Lookup/feedback/table-port bundle for bp_train_scheduler.
// slave: the scheduler side; master: the decode/EX/table side driving it.
interface bp_train_scheduler_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned IDX_BITS   = 4
);
  // Decode-stage lookup request
  logic                  i_req_valid;
  logic [ADDR_WIDTH-1:0] i_req_pc;
  // EX-stage branch resolution
  logic                  i_fb_valid;
  logic [ADDR_WIDTH-1:0] i_fb_pc;
  logic                  i_fb_prediction;
  logic                  i_fb_outcome;
  // Shared predictor table port
  logic                  o_tbl_en;
  logic                  o_tbl_we;
  logic [IDX_BITS-1:0]   o_tbl_idx;
  logic                  o_tbl_outcome;
  logic                  o_tbl_mispred;
  logic                  o_req_stall;

  modport slave (
    input  i_req_valid, i_req_pc,
    input  i_fb_valid, i_fb_pc, i_fb_prediction, i_fb_outcome,
    output o_tbl_en, o_tbl_we, o_tbl_idx, o_tbl_outcome, o_tbl_mispred,
    output o_req_stall
  );

  modport master (
    output i_req_valid, i_req_pc,
    output i_fb_valid, i_fb_pc, i_fb_prediction, i_fb_outcome,
    input  o_tbl_en, o_tbl_we, o_tbl_idx, o_tbl_outcome, o_tbl_mispred,
    input  o_req_stall
  );
endinterface

// File: rtl/bp_train_scheduler.sv
// bp_train_scheduler: arbitrates a single predictor-table port between decode
// lookups and read-modify-write training driven from a small feedback FIFO.
// Lookups normally win; a starvation counter forces training through after
// STARVE_LIMIT consecutive deferrals, stalling decode for that cycle.
// Optional macro BP_SCHED_STATS_EN adds o_pred_count / o_miss_count.
module bp_train_scheduler #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned IDX_BITS     = 4,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  bp_train_scheduler_if.slave      bus,
  output logic                     o_fb_drop,
  output logic [$clog2(DEPTH):0]   o_fifo_count
`ifdef BP_SCHED_STATS_EN
  ,
  output logic [31:0]              o_pred_count,
  output logic [31:0]              o_miss_count
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_TRAIN_RD = 2'd1;
  localparam logic [1:0] S_TRAIN_WR = 2'd2;

  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic [IDX_BITS-1:0] idx;
    logic                outcome;
    logic                mispred;
  } fb_entry_t;

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [STV_W-1:0]    r_starve;
  logic [STV_W-1:0]    w_starve_nxt;

  fb_entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    w_count_nxt;

  fb_entry_t           w_head;
  fb_entry_t           w_fb_entry;
  logic [IDX_BITS-1:0] w_req_idx;

  logic                w_train_active;
  logic                w_train_grant;
  logic                w_req_grant;
  logic                w_full;
  logic                w_pop;
  logic                w_push;
  logic                w_drop;

  logic                w_tbl_en;
  logic                w_tbl_we;
  logic [IDX_BITS-1:0] w_tbl_idx;
  logic                w_tbl_outcome;
  logic                w_tbl_mispred;
  logic                w_req_stall;

  // Only PC bits [IDX_BITS+1:2] feed the index hash
  logic                w_unused_pc_bits;
  assign w_unused_pc_bits = ^{bus.i_req_pc[ADDR_WIDTH-1:IDX_BITS+2], bus.i_req_pc[1:0],
                              bus.i_fb_pc[ADDR_WIDTH-1:IDX_BITS+2], bus.i_fb_pc[1:0]};

  assign w_req_idx          = bus.i_req_pc[IDX_BITS+1:2];
  assign w_fb_entry.idx     = bus.i_fb_pc[IDX_BITS+1:2];
  assign w_fb_entry.outcome = bus.i_fb_outcome;
  assign w_fb_entry.mispred = bus.i_fb_prediction ^ bus.i_fb_outcome;
  assign w_head             = r_mem[r_rd_ptr];

  // Port arbitration: lookups win unless training has been starved too long
  always_comb begin
    w_train_active = !rst && ((r_state == S_TRAIN_RD) || (r_state == S_TRAIN_WR));
    w_train_grant  = w_train_active && (!bus.i_req_valid || (r_starve == STV_MAX));
    w_req_grant    = !rst && bus.i_req_valid && !w_train_grant;
    w_pop          = w_train_grant && (r_state == S_TRAIN_WR);
    w_full         = (r_count == CNT_FULL);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    w_push         = !rst && bus.i_fb_valid && (!w_full || w_pop);
    w_drop         = !rst && bus.i_fb_valid && w_full && !w_pop;
    w_count_nxt    = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  end

  // Next state, starvation counter and table port drive
  always_comb begin
    w_state_nxt   = r_state;
    w_starve_nxt  = r_starve;
    w_tbl_en      = 1'b0;
    w_tbl_we      = 1'b0;
    w_tbl_idx     = '0;
    w_tbl_outcome = 1'b0;
    w_tbl_mispred = 1'b0;
    w_req_stall   = bus.i_req_valid && w_train_grant;

    case (r_state)
      S_IDLE: begin
        w_starve_nxt = '0;
        // A push this cycle lets the read go out on the very next cycle
        if (w_count_nxt != '0) begin
          w_state_nxt = S_TRAIN_RD;
        end
      end
      S_TRAIN_RD: begin
        if (w_train_grant) begin
          w_tbl_en    = 1'b1;
          w_tbl_idx   = w_head.idx;
          w_state_nxt = S_TRAIN_WR;
        end
      end
      S_TRAIN_WR: begin
        if (w_train_grant) begin
          w_tbl_en      = 1'b1;
          w_tbl_we      = 1'b1;
          w_tbl_idx     = w_head.idx;
          w_tbl_outcome = w_head.outcome;
          w_tbl_mispred = w_head.mispred;
          w_state_nxt   = (w_count_nxt != '0) ? S_TRAIN_RD : S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_train_active) begin
      if (w_train_grant) begin
        w_starve_nxt = '0;
      end else if (r_starve != STV_MAX) begin
        w_starve_nxt = r_starve + STV_W'(1);
      end
    end

    if (w_req_grant) begin
      w_tbl_en  = 1'b1;
      w_tbl_we  = 1'b0;
      w_tbl_idx = w_req_idx;
    end
  end

  assign bus.o_tbl_en      = w_tbl_en;
  assign bus.o_tbl_we      = w_tbl_we;
  assign bus.o_tbl_idx     = w_tbl_idx;
  assign bus.o_tbl_outcome = w_tbl_outcome;
  assign bus.o_tbl_mispred = w_tbl_mispred;
  assign bus.o_req_stall   = w_req_stall;
  assign o_fb_drop         = w_drop;
  assign o_fifo_count      = r_count;

  // FSM state and starvation counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_starve <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_starve <= w_starve_nxt;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  // FIFO storage; contents are don't-care while the count says empty
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_fb_entry;
    end
  end

`ifdef BP_SCHED_STATS_EN
  logic [31:0] r_pred_count;
  logic [31:0] r_miss_count;

  // Accepted-lookup and pushed-mispredict counters, free-running wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pred_count <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_req_grant) begin
        r_pred_count <= r_pred_count + 32'd1;
      end
      if (w_push && w_fb_entry.mispred) begin
        r_miss_count <= r_miss_count + 32'd1;
      end
    end
  end

  assign o_pred_count = r_pred_count;
  assign o_miss_count = r_miss_count;

`ifdef SIMULATION
  int unsigned sim_pred_events;
  int unsigned sim_miss_events;

  function automatic void stats_event(input string name);
    if (name == "branch_pred") sim_pred_events = sim_pred_events + 1;
    if (name == "branch_miss") sim_miss_events = sim_miss_events + 1;
  endfunction

  // Simulation-only statistics event hook, one call per counter increment
  always @(posedge clk) begin
    if (!rst && w_req_grant) stats_event("branch_pred");
    if (!rst && w_push && w_fb_entry.mispred) stats_event("branch_miss");
  end
`endif
`else
  // Statistics disabled: no counters and no statistics ports.
`endif

endmodule

// File: tb/tb_bp_train_scheduler.sv
// Scoreboard bench for bp_train_scheduler: stimulus pushes the expected
// table-port activity for each cycle; a negedge monitor pops and compares.
module tb_bp_train_scheduler;

  localparam int unsigned AW    = 32;
  localparam int unsigned IB    = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned SL    = 3;
  localparam logic [31:0] RPC   = 32'h0000_1008; // lookup PC, index 2

  typedef struct packed {
    logic          en;
    logic          we;
    logic [IB-1:0] idx;
    logic          outcome;
    logic          mispred;
    logic          stall;
    logic          drop;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bp_train_scheduler_if #(.ADDR_WIDTH(AW), .IDX_BITS(IB)) bus();
  logic       fb_drop;
  logic [2:0] fifo_count;
`ifdef BP_SCHED_STATS_EN
  logic [31:0] pred_count;
  logic [31:0] miss_count;
`endif

  bp_train_scheduler #(
    .ADDR_WIDTH(AW), .IDX_BITS(IB), .DEPTH(DEPTH), .STARVE_LIMIT(SL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .o_fb_drop    (fb_drop),
    .o_fifo_count (fifo_count)
`ifdef BP_SCHED_STATS_EN
    ,
    .o_pred_count (pred_count),
    .o_miss_count (miss_count)
`endif
  );

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic obs_t mk(input logic en, input logic we, input logic [IB-1:0] idx,
                              input logic o, input logic m, input logic s, input logic d);
    obs_t r;
    r.en = en; r.we = we; r.idx = idx; r.outcome = o; r.mispred = m; r.stall = s; r.drop = d;
    return r;
  endfunction

  function automatic obs_t rd(input logic [IB-1:0] idx, input logic s);
    return mk(1'b1, 1'b0, idx, 1'b0, 1'b0, s, 1'b0);
  endfunction

  function automatic obs_t wr(input logic [IB-1:0] idx, input logic o, input logic m, input logic s);
    return mk(1'b1, 1'b1, idx, o, m, s, 1'b0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // One cycle: drive inputs, register expected observable activity, advance
  task automatic step(input logic rv, input logic fv, input logic [31:0] fpc,
                      input logic fp, input logic fo, input bit has, input obs_t e);
    bus.i_req_valid     = rv;
    bus.i_req_pc        = RPC;
    bus.i_fb_valid      = fv;
    bus.i_fb_pc         = fpc;
    bus.i_fb_prediction = fp;
    bus.i_fb_outcome    = fo;
    if (has) exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // Monitor: compare every cycle with port activity against the scoreboard
  initial begin : monitor
    obs_t act;
    obs_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        act = mk(bus.o_tbl_en, bus.o_tbl_we, bus.o_tbl_idx, bus.o_tbl_outcome,
                 bus.o_tbl_mispred, bus.o_req_stall, fb_drop);
        if (act.en || act.stall || act.drop) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            $display("FAIL unexpected_activity @%0t: got %p expected none", $time, act);
          end else begin
            e = exp_q.pop_front();
            if (act === e) n_pass++;
            else $display("FAIL port_activity @%0t: got %p expected %p", $time, act, e);
          end
        end else begin
          check("idle_port_zero", 32'({bus.o_tbl_idx, bus.o_tbl_outcome, bus.o_tbl_mispred}), 32'h0);
        end
      end
    end
  end

  initial begin : stimulus
    // Reset with live inputs: everything quiet, feedback discarded silently
    rst = 1'b1;
    bus.i_req_valid = 1'b1; bus.i_req_pc = RPC;
    bus.i_fb_valid = 1'b1; bus.i_fb_pc = 32'h40;
    bus.i_fb_prediction = 1'b0; bus.i_fb_outcome = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tbl_en", 32'(bus.o_tbl_en), 32'h0);
    check("rst_req_stall", 32'(bus.o_req_stall), 32'h0);
    check("rst_fb_drop", 32'(fb_drop), 32'h0);
    check("rst_fifo_count", 32'(fifo_count), 32'h0);
    rst = 1'b0;
    idle(1);
    check("post_rst_count", 32'(fifo_count), 32'h0);

    // Single mispredicted feedback, no lookups: read then write
    step(1'b0, 1'b1, 32'h40, 1'b0, 1'b1, 1'b0, '0);
    check("t1_count_after_push", 32'(fifo_count), 32'h1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, rd(4'h0, 1'b0));
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, wr(4'h0, 1'b1, 1'b1, 1'b0));
    check("t1_count_after_pop", 32'(fifo_count), 32'h0);
    idle(1);

    // Starvation: three deferrals then forced read, three more then forced write
    step(1'b1, 1'b1, 32'h44, 1'b1, 1'b0, 1'b1, rd(4'h2, 1'b0));
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, rd(4'h2, 1'b0));
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, rd(4'h1, 1'b1));
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, rd(4'h2, 1'b0));
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, wr(4'h1, 1'b0, 1'b1, 1'b1));
    check("t2_count_after_write", 32'(fifo_count), 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, rd(4'h2, 1'b0));
    idle(1);

    // Overflow: fifth back-to-back pulse is dropped
    step(1'b1, 1'b1, 32'h00, 1'b0, 1'b0, 1'b1, rd(4'h2, 1'b0));
    step(1'b1, 1'b1, 32'h04, 1'b0, 1'b0, 1'b1, rd(4'h2, 1'b0));
    step(1'b1, 1'b1, 32'h08, 1'b0, 1'b0, 1'b1, rd(4'h2, 1'b0));
    step(1'b1, 1'b1, 32'h0C, 1'b0, 1'b0, 1'b1, rd(4'h2, 1'b0));
    check("t3_count_full", 32'(fifo_count), 32'h4);
    step(1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 1'b1, mk(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1));
    check("t3_count_after_drop", 32'(fifo_count), 32'h4);
    // Full FIFO: push coinciding with the forced write pop is accepted
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, rd(4'h2, 1'b0));
    step(1'b1, 1'b1, 32'h14, 1'b1, 1'b1, 1'b1, wr(4'h0, 1'b0, 1'b0, 1'b1));
    check("t4_count_pop_push", 32'(fifo_count), 32'h4);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, rd(4'h1, 1'b0));
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, wr(4'h1, 1'b0, 1'b0, 1'b0));
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, rd(4'h2, 1'b0));
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, wr(4'h2, 1'b0, 1'b0, 1'b0));
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, rd(4'h3, 1'b0));
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, wr(4'h3, 1'b0, 1'b0, 1'b0));
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, rd(4'h5, 1'b0));
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, wr(4'h5, 1'b1, 1'b0, 1'b0));
    check("t4_count_drained", 32'(fifo_count), 32'h0);
    idle(1);

    // Reset while the write is being presented: abandoned, nothing after release
    step(1'b0, 1'b1, 32'h48, 1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, rd(4'h2, 1'b0));
    rst = 1'b1;
    bus.i_req_valid = 1'b1;
    bus.i_fb_valid  = 1'b1;
    #1;
    check("t5_rst_tbl_en", 32'(bus.o_tbl_en), 32'h0);
    check("t5_rst_tbl_we", 32'(bus.o_tbl_we), 32'h0);
    check("t5_rst_idx", 32'(bus.o_tbl_idx), 32'h0);
    check("t5_rst_stall", 32'(bus.o_req_stall), 32'h0);
    check("t5_rst_drop", 32'(fb_drop), 32'h0);
    check("t5_rst_count", 32'(fifo_count), 32'h0);
    @(posedge clk);
    #1;
    bus.i_req_valid = 1'b0;
    bus.i_fb_valid  = 1'b0;
    rst = 1'b0;
    idle(4);
    check("t5_count_after_release", 32'(fifo_count), 32'h0);

    // Statistics workload: 10 accepted lookups, 3 mispredicted feedbacks
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, rd(4'h2, 1'b0));
    step(1'b0, 1'b1, 32'h4C, 1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 32'h50, 1'b1, 1'b0, 1'b1, rd(4'h3, 1'b0));
    step(1'b0, 1'b1, 32'h54, 1'b1, 1'b0, 1'b1, wr(4'h3, 1'b0, 1'b1, 1'b0));
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, rd(4'h4, 1'b0));
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, wr(4'h4, 1'b0, 1'b1, 1'b0));
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, rd(4'h5, 1'b0));
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, wr(4'h5, 1'b0, 1'b1, 1'b0));
    idle(2);
    check("t6_count_drained", 32'(fifo_count), 32'h0);
`ifdef BP_SCHED_STATS_EN
    check("t6_pred_count", pred_count, 32'd10);
    check("t6_miss_count", miss_count, 32'd3);
`endif

    idle(2);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
